// File: rtl/sram_pump_arbiter.sv
// sram_pump_arbiter: shares one 512Kx8 SRAM between the SPI data pump (priority) and the core port.
module sram_pump_arbiter #(
  parameter int WR_CYCLES  = 2,
  parameter int RD_CYCLES  = 2,
  parameter int RESET_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        pump_active_i,
  input  logic [18:0] pump_a_i,
  input  logic [7:0]  pump_d_i,
  input  logic        pump_we_n_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [18:0] core_a_i,
  input  logic [7:0]  core_d_i,
  output logic [7:0]  core_q_o,
  output logic        core_ack_o,
  output logic        core_reset_o,
  output logic [18:0] sram_a_o,
  output logic [7:0]  sram_d_o,
  input  logic [7:0]  sram_d_i,
  output logic        sram_d_oe_o,
  output logic        sram_we_n_o,
  output logic        sram_oe_n_o,
  output logic [18:0] pump_count_o,
  output logic        pump_overrun_o
);
  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_PULSE, RD_DONE} state_t;
  state_t state, state_n;
  logic [2:0] we_s, act_s;
  logic [3:0] cnt;
  logic [7:0] hold;
  logic [18:0] cap_a;
  logic [7:0] cap_d;
  logic pend, src_pump, strobe, act_rise, pump_done;
  assign strobe = we_s[2] & ~we_s[1];
  assign act_rise = act_s[1] & ~act_s[2];
  assign pump_done = (state == WR_HOLD) & src_pump;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? 4'd0 : cnt + 4'd1;
    end
  always_comb begin
    state_n = state;
    sram_we_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_d_oe_o = 1'b0;
    core_ack_o = 1'b0;
    case (state)
      IDLE: state_n = pend ? WR_SETUP : core_req_i ? (core_we_i ? WR_SETUP : RD_PULSE) : IDLE;
      WR_SETUP: begin
        sram_d_oe_o = 1'b1;
        state_n = WR_PULSE;
      end
      WR_PULSE: begin
        sram_d_oe_o = 1'b1;
        sram_we_n_o = 1'b0;
        state_n = (cnt == 4'(WR_CYCLES - 1)) ? WR_HOLD : WR_PULSE;
      end
      WR_HOLD: begin
        sram_d_oe_o = 1'b1;
        core_ack_o = ~src_pump;
        state_n = IDLE;
      end
      RD_PULSE: begin
        sram_oe_n_o = 1'b0;
        state_n = (cnt == 4'(RD_CYCLES - 1)) ? RD_DONE : RD_PULSE;
      end
      RD_DONE: begin
        core_ack_o = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      sram_a_o <= '0;
      sram_d_o <= '0;
      src_pump <= 1'b0;
      core_q_o <= '0;
    end else begin
      if (state == IDLE && (pend || core_req_i)) begin
        src_pump <= pend;
        sram_a_o <= pend ? cap_a : core_a_i;
        sram_d_o <= pend ? cap_d : core_d_i;
      end
      if (state == RD_PULSE && state_n == RD_DONE) core_q_o <= sram_d_i;
    end
  // core reset follows synced pump_active, then a RESET_HOLD tail that also waits out a pending pump write
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      we_s <= 3'b111;
      act_s <= 3'b000;
      pend <= 1'b0;
      cap_a <= '0;
      cap_d <= '0;
      pump_count_o <= '0;
      pump_overrun_o <= 1'b0;
      hold <= 8'(RESET_HOLD);
      core_reset_o <= 1'b1;
    end else begin
      we_s <= {we_s[1:0], pump_we_n_i};
      act_s <= {act_s[1:0], pump_active_i};
      if (strobe && !pend) begin
        cap_a <= pump_a_i;
        cap_d <= pump_d_i;
      end
      pend <= (strobe && !pend) || (pend && !pump_done);
      pump_overrun_o <= ~act_rise & (pump_overrun_o | (strobe & pend));
      pump_count_o <= act_rise ? 19'd0 : pump_count_o + 19'(pump_done);
      hold <= act_s[1] ? 8'(RESET_HOLD) : hold - 8'(hold != 8'd0);
      core_reset_o <= act_s[1] | (core_reset_o & ((hold > 8'd1) | pend));
    end
endmodule

// File: tb/tb_sram_pump_arbiter.sv
// tb_sram_pump_arbiter: directed vectors with a scoreboard of expected SRAM writes and core acks.
module tb_sram_pump_arbiter;
  logic clk_sys = 1'b0, reset_n = 1'b0;
  logic pump_active_i = 1'b0, pump_we_n_i = 1'b1;
  logic [18:0] pump_a_i = '0, core_a_i = '0;
  logic [7:0] pump_d_i = '0, core_d_i = '0;
  logic core_req_i = 1'b0, core_we_i = 1'b0;
  logic [7:0] core_q_o, sram_d_o, sram_d_i;
  logic core_ack_o, core_reset_o, sram_d_oe_o, sram_we_n_o, sram_oe_n_o, pump_overrun_o;
  logic [18:0] sram_a_o, pump_count_o;
  logic [7:0] mem [0:524287];
  typedef struct {logic [18:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic rd; logic [7:0] q; int at;} ack_t;
  wr_t exp_wr[$];
  ack_t exp_ack[$];
  wr_t mw;
  ack_t ma;
  int cyc = 0, vectors = 0, miscompares = 0, overlaps = 0, wr_len = 0;
  logic [18:0] wa;
  logic [7:0] wd;

  sram_pump_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pump_active_i(pump_active_i), .pump_a_i(pump_a_i),
    .pump_d_i(pump_d_i), .pump_we_n_i(pump_we_n_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_a_i(core_a_i), .core_d_i(core_d_i), .core_q_o(core_q_o), .core_ack_o(core_ack_o),
    .core_reset_o(core_reset_o), .sram_a_o(sram_a_o), .sram_d_o(sram_d_o), .sram_d_i(sram_d_i),
    .sram_d_oe_o(sram_d_oe_o), .sram_we_n_o(sram_we_n_o), .sram_oe_n_o(sram_oe_n_o),
    .pump_count_o(pump_count_o), .pump_overrun_o(pump_overrun_o)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;
  assign sram_d_i = sram_oe_n_o ? 8'h00 : mem[sram_a_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push_wr(input logic [18:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic pump(input logic [18:0] a, input logic [7:0] d);
    push_wr(a, d);
    pump_a_i = a;
    pump_d_i = d;
    pump_we_n_i = 1'b0;
    tick(2);
    pump_we_n_i = 1'b1;
    tick(8);
  endtask

  // lat < 0 means the request may be delayed by a pump write, so ack timing is not checked
  task automatic core_access(input logic we, input logic [18:0] a, input logic [7:0] d,
                             input logic [7:0] q, input int lat);
    ack_t k;
    int n;
    if (we) push_wr(a, d);
    k.rd = ~we;
    k.q = q;
    k.at = (lat < 0) ? -1 : cyc + lat;
    exp_ack.push_back(k);
    core_req_i = 1'b1;
    core_we_i = we;
    core_a_i = a;
    core_d_i = d;
    n = 0;
    while (n < 40) begin
      @(negedge clk_sys);
      if (core_ack_o) break;
      n++;
    end
    if (n >= 40) check("ack_timeout", 0, 1);
    tick(1);
    core_req_i = 1'b0;
    tick(1);
  endtask

  always @(negedge clk_sys) begin
    if (sram_d_oe_o && !sram_oe_n_o) overlaps++;
    if (!reset_n) wr_len = 0;
    else if (!sram_we_n_o) begin
      wr_len++;
      wa = sram_a_o;
      wd = sram_d_o;
      mem[wa] = wd;
    end else if (wr_len > 0) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        mw = exp_wr.pop_front();
        check("wr_addr", 32'(wa), 32'(mw.a));
        check("wr_data", 32'(wd), 32'(mw.d));
        check("we_width", wr_len, 2);
      end
      wr_len = 0;
    end
    if (core_ack_o) begin
      if (exp_ack.size() == 0) check("ack_unexpected", 1, 0);
      else begin
        ma = exp_ack.pop_front();
        if (ma.rd) check("rd_q", 32'(core_q_o), 32'(ma.q));
        if (ma.at >= 0) check("ack_cycle", cyc, ma.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    tick(2);
    check("rst_we_n", 32'(sram_we_n_o), 1);
    check("rst_oe_n", 32'(sram_oe_n_o), 1);
    check("rst_d_oe", 32'(sram_d_oe_o), 0);
    check("rst_addr", 32'(sram_a_o), 0);
    check("rst_data", 32'(sram_d_o), 0);
    check("rst_ack", 32'(core_ack_o), 0);
    check("rst_q", 32'(core_q_o), 0);
    check("rst_core_reset", 32'(core_reset_o), 1);
    check("rst_count", 32'(pump_count_o), 0);
    check("rst_overrun", 32'(pump_overrun_o), 0);
    reset_n = 1'b1;
    tick(2);
    pump_active_i = 1'b1;
    tick(4);
    pump(19'h00000, 8'hAA);
    pump(19'h00001, 8'h55);
    pump(19'h00002, 8'h3C);
    tick(4);
    check("s1_count", 32'(pump_count_o), 3);
    check("s1_core_reset", 32'(core_reset_o), 1);
    check("s1_mem0", 32'(mem[0]), 32'hAA);
    check("s1_mem1", 32'(mem[1]), 32'h55);
    check("s1_mem2", 32'(mem[2]), 32'h3C);
    pump_active_i = 1'b0;
    tick(17);
    check("tail_still_held", 32'(core_reset_o), 1);
    tick(1);
    check("tail_released", 32'(core_reset_o), 0);
    pump_active_i = 1'b1;
    tick(4);
    check("s2_count_cleared", 32'(pump_count_o), 0);
    check("s2_core_reset", 32'(core_reset_o), 1);
    push_wr(19'h00003, 8'h99);
    pump_a_i = 19'h00003;
    pump_d_i = 8'h99;
    pump_we_n_i = 1'b0;
    tick(1);
    pump_active_i = 1'b0;
    tick(1);
    pump_we_n_i = 1'b1;
    tick(16);
    check("s2_tail_held", 32'(core_reset_o), 1);
    tick(1);
    check("s2_tail_released", 32'(core_reset_o), 0);
    check("s2_count_late", 32'(pump_count_o), 1);
    check("s2_mem3", 32'(mem[3]), 32'h99);
    tick(2);
    core_access(1'b1, 19'h40000, 8'h12, 8'h00, 4);
    core_access(1'b0, 19'h40000, 8'h00, 8'h12, 3);
    tick(3);
    check("q_held", 32'(core_q_o), 32'h12);
    push_wr(19'h00010, 8'hC3);
    pump_a_i = 19'h00010;
    pump_d_i = 8'hC3;
    pump_we_n_i = 1'b0;
    tick(2);
    pump_we_n_i = 1'b1;
    tick(1);
    core_access(1'b1, 19'h00020, 8'h5A, 8'h00, -1);
    tick(4);
    check("prio_pump_mem", 32'(mem[19'h10]), 32'hC3);
    check("prio_core_mem", 32'(mem[19'h20]), 32'h5A);
    pump_active_i = 1'b1;
    tick(4);
    fork
      core_access(1'b1, 19'h00200, 8'h11, 8'h00, 4);
      begin
        pump_a_i = 19'h00100;
        pump_d_i = 8'h77;
        pump_we_n_i = 1'b0;
        tick(1);
        push_wr(19'h00100, 8'h77);
        pump_we_n_i = 1'b1;
        tick(3);
        pump_a_i = 19'h00101;
        pump_d_i = 8'h88;
        pump_we_n_i = 1'b0;
        tick(1);
        pump_we_n_i = 1'b1;
      end
    join
    tick(10);
    check("ovr_flag", 32'(pump_overrun_o), 1);
    check("ovr_count", 32'(pump_count_o), 1);
    check("ovr_first_kept", 32'(mem[19'h100]), 32'h77);
    check("ovr_second_dropped", 32'(mem[19'h101]), 0);
    check("ovr_core_mem", 32'(mem[19'h200]), 32'h11);
    pump_active_i = 1'b0;
    tick(3);
    pump_active_i = 1'b1;
    tick(4);
    check("ovr_cleared", 32'(pump_overrun_o), 0);
    check("ovr_count_cleared", 32'(pump_count_o), 0);
    pump_a_i = 19'h00007;
    pump_d_i = 8'hEE;
    pump_we_n_i = 1'b0;
    tick(2);
    pump_we_n_i = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk_sys);
      if (!sram_we_n_o) break;
      n++;
    end
    if (n >= 20) check("we_low_timeout", 0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_we_n", 32'(sram_we_n_o), 1);
    check("async_d_oe", 32'(sram_d_oe_o), 0);
    check("async_addr", 32'(sram_a_o), 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_count", 32'(pump_count_o), 0);
    check("post_rst_core_reset", 32'(core_reset_o), 1);
    core_access(1'b0, 19'h40000, 8'h00, 8'h12, 3);
    tick(2);
    check("oe_doe_overlap", overlaps, 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("ack_queue_empty", exp_ack.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
